// File: rtl/program_encoder_if.sv
// Field-beat stream feeding program_encoder: decoded instruction fields
// carried with a valid/ready handshake and an end-of-program marker.
interface program_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target,
    output in_ready
  );
endinterface

// File: rtl/program_encoder.sv
// Streaming MIPS instruction encoder and instruction-memory loader.
// Optional macro PROG_ENCODER_NOP_PAD_EN fills the unused memory tail with nops after the last beat.
module program_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_encoder_if.slave  beat,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH    = CNT_W'((32'd1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_ONE  = CNT_W'(32'd1);
  localparam logic [ADDR_W:0]   CNT_ZERO = CNT_W'(32'd0);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);

`ifdef PROG_ENCODER_NOP_PAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_PAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;
`endif

  function automatic logic [5:0] opcode_of(input logic [3:0] sel);
    logic [5:0] op;
    case (sel)
      4'd1:    op = 6'b100011;
      4'd2:    op = 6'b101011;
      4'd3:    op = 6'b000100;
      4'd4:    op = 6'b000101;
      4'd5:    op = 6'b000010;
      4'd6:    op = 6'b001000;
      4'd7:    op = 6'b001001;
      4'd8:    op = 6'b001100;
      4'd9:    op = 6'b001101;
      4'd10:   op = 6'b001010;
      4'd11:   op = 6'b001011;
      default: op = 6'b000000;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] encode_word(
    input logic [3:0]  sel,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_shamt,
    input logic [5:0]  f_funct,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [31:0] w;
    case (sel)
      4'd0:    w = {6'b000000, f_rs, f_rt, f_rd, f_shamt, f_funct};
      4'd5:    w = {6'b000010, f_target};
      default: w = {opcode_of(sel), f_rs, f_rt, f_imm};
    endcase
    return w;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic              in_ready_r;
  logic              we_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              ovf_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   claimed_s;
  logic              accept_s;
  logic              legal_s;
  logic              full_s;
  logic              write_s;
  logic              pad_write_s;
  logic              arm_s;
  logic              busy_next_s;

  assign beat.in_ready = in_ready_r;
  // Reset aborts a write that is already on the bus in the same cycle.
  assign imem_we    = we_r & ~reset;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign overflow   = ovf_r;

  // claimed_s counts the slot taken by a write still in flight this cycle.
  assign accept_s  = beat.in_valid & in_ready_r;
  assign legal_s   = (beat.op_sel <= 4'd11);
  assign claimed_s = count_r + (we_r ? CNT_ONE : CNT_ZERO);
  assign full_s    = (claimed_s == DEPTH);
  assign write_s   = accept_s & legal_s & ~full_s;
  assign arm_s     = start & ((state_r == S_IDLE) | (state_r == S_DONE));

`ifdef PROG_ENCODER_NOP_PAD_EN
  logic [ADDR_W:0] claimed_next_s;
  assign claimed_next_s = claimed_s + (write_s ? CNT_ONE : CNT_ZERO);
  assign busy_next_s    = (next_state_s == S_LOAD) | (next_state_s == S_PAD);
`else
  assign busy_next_s    = (next_state_s == S_LOAD);
`endif

  // Next-state selection and nop-pad write request
  always_comb begin
    next_state_s = state_r;
    pad_write_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_LOAD;
        else       next_state_s = S_IDLE;
      end
      S_LOAD: begin
        if (accept_s && beat.in_last) begin
`ifdef PROG_ENCODER_NOP_PAD_EN
          if (claimed_next_s == DEPTH) next_state_s = S_DONE;
          else                         next_state_s = S_PAD;
`else
          next_state_s = S_DONE;
`endif
        end else begin
          next_state_s = S_LOAD;
        end
      end
      S_DONE: begin
        if (start) next_state_s = S_LOAD;
        else       next_state_s = S_DONE;
      end
`ifdef PROG_ENCODER_NOP_PAD_EN
      S_PAD: begin
        if (!full_s) begin
          pad_write_s = 1'b1;
          if ((claimed_s + CNT_ONE) == DEPTH) next_state_s = S_DONE;
          else                                next_state_s = S_PAD;
        end else begin
          next_state_s = S_DONE;
        end
      end
`endif
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, session counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      ovf_r      <= 1'b0;
      addr_r     <= BASE;
      wdata_r    <= 32'h0000_0000;
      count_r    <= CNT_ZERO;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == S_LOAD);
      busy_r     <= busy_next_s;
      done_r     <= (next_state_s == S_DONE);
      we_r       <= write_s | pad_write_s;
      if (write_s) begin
        wdata_r <= encode_word(beat.op_sel, beat.rs, beat.rt, beat.rd,
                               beat.shamt, beat.funct, beat.imm, beat.target);
      end else if (pad_write_s) begin
        wdata_r <= 32'h0000_0000;
      end else begin
        wdata_r <= wdata_r;
      end
      if (arm_s) begin
        count_r <= CNT_ZERO;
        addr_r  <= BASE;
        err_r   <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        // The address parks on the last slot instead of wrapping.
        if (we_r) begin
          count_r <= count_r + CNT_ONE;
          if ((count_r + CNT_ONE) != DEPTH) addr_r <= addr_r + ADDR_ONE;
          else                              addr_r <= addr_r;
        end
        if (accept_s && !legal_s)          err_r <= 1'b1;
        if (accept_s && legal_s && full_s) ovf_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: two instances (ADDR_W=8 and ADDR_W=2) fed the same beat
// stream, checked against a session-level memory model. Honours PROG_ENCODER_NOP_PAD_EN.
`timescale 1ns/1ps
module tb_program_encoder;
`ifdef PROG_ENCODER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int DEPTH_A = 256;
  localparam int DEPTH_B = 4;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
    logic [31:0] exp;
  } beat_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [3:0]  s_op = 4'd0;
  logic [4:0]  s_rs = 5'd0, s_rt = 5'd0, s_rd = 5'd0, s_shamt = 5'd0;
  logic [5:0]  s_funct = 6'd0;
  logic [15:0] s_imm = 16'd0;
  logic [25:0] s_target = 26'd0;

  logic        we_a, busy_a, done_a, err_a, ovf_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;
  logic        we_b, busy_b, done_b, err_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  wr_t obs_a[$];
  wr_t obs_b[$];
  int  acc_q[$];

  program_encoder_if bus_a();
  program_encoder_if bus_b();

  assign bus_a.in_valid = s_valid;  assign bus_b.in_valid = s_valid;
  assign bus_a.in_last  = s_last;   assign bus_b.in_last  = s_last;
  assign bus_a.op_sel   = s_op;     assign bus_b.op_sel   = s_op;
  assign bus_a.rs       = s_rs;     assign bus_b.rs       = s_rs;
  assign bus_a.rt       = s_rt;     assign bus_b.rt       = s_rt;
  assign bus_a.rd       = s_rd;     assign bus_b.rd       = s_rd;
  assign bus_a.shamt    = s_shamt;  assign bus_b.shamt    = s_shamt;
  assign bus_a.funct    = s_funct;  assign bus_b.funct    = s_funct;
  assign bus_a.imm      = s_imm;    assign bus_b.imm      = s_imm;
  assign bus_a.target   = s_target; assign bus_b.target   = s_target;

  program_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .beat(bus_a),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .count(count_a),
    .busy(busy_a), .done(done_a), .err(err_a), .overflow(ovf_a)
  );

  program_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .beat(bus_b),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .count(count_b),
    .busy(busy_b), .done(done_b), .err(err_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_a === 1'b1) obs_a.push_back('{addr: int'(addr_a), data: wdata_a, cyc: cyc});
    if (we_b === 1'b1) obs_b.push_back('{addr: int'(addr_b), data: wdata_b, cyc: cyc});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Opcode table and word formats straight from the instruction-set definition.
  function automatic logic [31:0] ref_encode(input beat_t b);
    logic [5:0] opc [12];
    opc = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001011};
    if (b.op == 4'd0) return {6'b000000, b.rs, b.rt, b.rd, b.shamt, b.funct};
    if (b.op == 4'd5) return {6'b000010, b.target};
    return {opc[int'(b.op)], b.rs, b.rt, b.imm};
  endfunction

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.op     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
    b.rs     = 5'($urandom);
    b.rt     = 5'($urandom);
    b.rd     = 5'($urandom);
    b.shamt  = 5'($urandom);
    b.funct  = 6'($urandom);
    b.imm    = 16'($urandom);
    b.target = 26'($urandom);
    b.last   = last;
    b.exp    = (b.op <= 4'd11) ? ref_encode(b) : 32'h0;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    s_op = b.op; s_rs = b.rs; s_rt = b.rt; s_rd = b.rd; s_shamt = b.shamt;
    s_funct = b.funct; s_imm = b.imm; s_target = b.target; s_last = b.last;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input beat_t b, input int gap, input bit with_start);
    bit ok = 1'b0;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    drive(b);
    s_valid = 1'b1;
    start   = with_start;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    s_valid = 1'b0;
    start   = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_dut(input string tag, input int depth, input beat_t q[$], input int acc[$],
                           input wr_t obs[$], input int cnt, input logic e, input logic o,
                           input logic d, input logic bz, input logic rdy, input int addr);
    wr_t exp[$];
    int  n = 0;
    bit  xe = 1'b0, xo = 1'b0;
    foreach (q[i]) begin
      if (q[i].op > 4'd11) xe = 1'b1;
      else if (n < depth) begin exp.push_back('{addr: n, data: q[i].exp, cyc: acc[i]}); n++; end
      else xo = 1'b1;
    end
    if (PAD_EN) while (exp.size() < depth) exp.push_back('{addr: exp.size(), data: 32'h0, cyc: -1});
    chk($sformatf("%s_nwrites", tag), 64'(obs.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < obs.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(obs[i].addr), 64'(exp[i].addr));
        chk($sformatf("%s_data%0d", tag, i), 64'(obs[i].data), 64'(exp[i].data));
        if (exp[i].cyc >= 0) chk($sformatf("%s_wcyc%0d", tag, i), 64'(obs[i].cyc), 64'(exp[i].cyc));
      end
    end
    chk($sformatf("%s_count", tag), 64'(cnt), 64'(exp.size()));
    chk($sformatf("%s_err", tag), 64'(e), 64'(xe));
    chk($sformatf("%s_overflow", tag), 64'(o), 64'(xo));
    chk($sformatf("%s_done", tag), 64'(d), 64'd1);
    chk($sformatf("%s_busy", tag), 64'(bz), 64'd0);
    chk($sformatf("%s_ready", tag), 64'(rdy), 64'd0);
    chk($sformatf("%s_final_addr", tag), 64'(addr),
        64'((exp.size() == 0) ? 0 : ((exp.size() < depth) ? exp.size() : depth - 1)));
  endtask

  // A decoy beat is offered with start and must never be written.
  task automatic run_session(input string tag, input beat_t q[$], input bit rnd);
    bit ok = 1'b0;
    obs_a.delete(); obs_b.delete(); acc_q.delete();
    drive(q[0]);
    s_valid = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
    foreach (q[i]) send_beat(q[i], rnd ? int'($urandom_range(0, 2)) : 0,
                             rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
    for (int w = 0; w < 700; w++) begin
      @(negedge clk);
      if (done_a === 1'b1 && done_b === 1'b1) begin ok = 1'b1; break; end
    end
    chk($sformatf("%s_done_seen", tag), 64'(ok), 64'd1);
    @(negedge clk);
    check_dut({tag, "_a"}, DEPTH_A, q, acc_q, obs_a, int'(count_a), err_a, ovf_a, done_a, busy_a,
              bus_a.in_ready, int'(addr_a));
    check_dut({tag, "_b"}, DEPTH_B, q, acc_q, obs_b, int'(count_b), err_b, ovf_b, done_b, busy_b,
              bus_b.in_ready, int'(addr_b));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t tbl[12];
    beat_t sess[$];
    beat_t b;
    int    sn = 0;

    //          op     rs     rt     rd     shamt  funct   imm        target        last  expected
    tbl[0]  = '{4'd6,  5'd0,  5'd8,  5'd0,  5'd0,  6'd0,   16'h0005,  26'd0,        1'b1, 32'h20080005};
    tbl[1]  = '{4'd0,  5'd9,  5'd10, 5'd8,  5'd0,  6'h20,  16'h1234,  26'd0,        1'b0, 32'h012A4020};
    tbl[2]  = '{4'd1,  5'd29, 5'd8,  5'd0,  5'd0,  6'd0,   16'h0004,  26'd0,        1'b0, 32'h8FA80004};
    tbl[3]  = '{4'd5,  5'd7,  5'd0,  5'd0,  5'd0,  6'd0,   16'hFFFF,  26'h10,       1'b1, 32'h08000010};
    tbl[4]  = '{4'd9,  5'd1,  5'd2,  5'd0,  5'd0,  6'd0,   16'h00FF,  26'd0,        1'b0, 32'h342200FF};
    tbl[5]  = '{4'd13, 5'd3,  5'd3,  5'd3,  5'd0,  6'd0,   16'h0001,  26'd0,        1'b0, 32'h00000000};
    tbl[6]  = '{4'd11, 5'd3,  5'd4,  5'd0,  5'd0,  6'd0,   16'hFFFF,  26'd0,        1'b1, 32'h2C64FFFF};
    tbl[7]  = '{4'd2,  5'd31, 5'd0,  5'd31, 5'd31, 6'h3F,  16'h8000,  26'h3FFFFFF,  1'b0, 32'hAFE08000};
    tbl[8]  = '{4'd3,  5'd1,  5'd2,  5'd0,  5'd0,  6'd0,   16'hFFFE,  26'd0,        1'b0, 32'h1022FFFE};
    tbl[9]  = '{4'd4,  5'd5,  5'd6,  5'd0,  5'd0,  6'd0,   16'h0003,  26'd0,        1'b0, 32'h14A60003};
    tbl[10] = '{4'd8,  5'd7,  5'd8,  5'd0,  5'd0,  6'd0,   16'h0F0F,  26'd0,        1'b0, 32'h30E80F0F};
    tbl[11] = '{4'd10, 5'd2,  5'd2,  5'd0,  5'd0,  6'd0,   16'h0001,  26'd0,        1'b1, 32'h28420001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_a", 64'(we_a), 64'd0);
    chk("rst_addr_a", 64'(addr_a), 64'd0);
    chk("rst_wdata_a", 64'(wdata_a), 64'd0);
    chk("rst_count_a", 64'(count_a), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_err_a", 64'(err_a), 64'd0);
    chk("rst_ovf_a", 64'(ovf_a), 64'd0);
    chk("rst_ready_a", 64'(bus_a.in_ready), 64'd0);
    chk("rst_count_b", 64'(count_b), 64'd0);
    chk("rst_ready_b", 64'(bus_b.in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    drive(tbl[1]);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", 64'(bus_a.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_write_a", 64'(obs_a.size()), 64'd0);
    chk("idle_no_write_b", 64'(obs_b.size()), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      sess.push_back(tbl[i]);
      if (tbl[i].last) begin
        run_session($sformatf("tbl%0d", sn), sess, 1'b0);
        sess.delete();
        sn++;
      end
    end

    // Reset in the cycle after an accepted beat aborts its write.
    obs_a.delete(); obs_b.delete(); acc_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = tbl[0];
    b.last = 1'b0;
    send_beat(b, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_a", 64'(we_a), 64'd0);
    chk("rst_mid_we_b", 64'(we_b), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_we_after", 64'(we_a), 64'd0);
    chk("rst_mid_busy", 64'(busy_a), 64'd0);
    chk("rst_mid_ready", 64'(bus_a.in_ready), 64'd0);
    chk("rst_mid_count", 64'(count_a), 64'd0);
    chk("rst_mid_done", 64'(done_a), 64'd0);
    chk("rst_mid_nwrites", 64'(obs_a.size()), 64'd0);
    @(posedge clk); #1;

    for (int s = 0; s < 25; s++) begin
      int n = int'($urandom_range(1, 8));
      sess.delete();
      for (int i = 0; i < n; i++) sess.push_back(rand_beat(i == n - 1));
      run_session($sformatf("rnd%0d", s), sess, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
